// File: rtl/reg_readback_sequencer.sv
// Register readback sequencer: walks a contiguous address range through a
// combinational read port and streams each word out on a valid/ready interface.
module reg_readback_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  clear_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] baseAddr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] regAddr,
    input  logic [DATA_WIDTH-1:0] regData,
    output logic [DATA_WIDTH-1:0] outData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbgState
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_PRESENT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH:0]     remaining_q;
    logic [ADDR_WIDTH-1:0]   reg_addr_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic                    out_valid_q;
    logic                    busy_q;
    logic                    done_q;

    // Stream handshake: a word transfers on any rising edge where outValid and
    // outReady are both high; outValid never drops without that transfer.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            reg_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (count != '0) begin
                            addr_q      <= baseAddr;
                            reg_addr_q  <= baseAddr;
                            remaining_q <= count;
                            state_q     <= S_FETCH;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_FETCH: begin
                    // Snapshot here so later register writes cannot disturb the word on offer.
                    out_data_q  <= regData;
                    out_valid_q <= 1'b1;
                    state_q     <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (outReady) begin
                        out_valid_q <= 1'b0;
                        if (remaining_q == (ADDR_WIDTH+1)'(1)) begin
                            remaining_q <= '0;
                            done_q      <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            remaining_q <= remaining_q - 1'b1;
                            addr_q      <= addr_q + 1'b1;
                            reg_addr_q  <= addr_q + 1'b1;
                            state_q     <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign regAddr  = reg_addr_q;
    assign outData  = out_data_q;
    assign outValid = out_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign dbgState = state_q;

endmodule

// File: tb/tb_reg_readback_sequencer.sv
// Directed bench for reg_readback_sequencer: table of readback runs plus a
// hand-written reset-abort sequence, with an expected-word queue.
module tb_reg_readback_sequencer;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          clear_n;
    logic          start;
    logic [AW-1:0] baseAddr;
    logic [AW:0]   count;
    logic [AW-1:0] regAddr;
    logic [DW-1:0] regData;
    logic [DW-1:0] outData;
    logic          outValid;
    logic          outReady;
    logic          busy;
    logic          done;
    logic [1:0]    dbgState;

    logic [DW-1:0] regs [32];
    logic [DW-1:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   cnt;
        int            stall_word;
        int            stall_len;
        bit            noisy;
        logic [DW-1:0] exp_first;
        logic [AW-1:0] exp_last_addr;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    assign regData = regs[regAddr];

    reg_readback_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .clear_n  (clear_n),
        .start    (start),
        .baseAddr (baseAddr),
        .count    (count),
        .regAddr  (regAddr),
        .regData  (regData),
        .outData  (outData),
        .outValid (outValid),
        .outReady (outReady),
        .busy     (busy),
        .done     (done),
        .dbgState (dbgState)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_readback(input vec_t v);
        logic [AW-1:0] a;
        logic [DW-1:0] w;
        int n;
        n = int'(v.cnt);
        for (int i = 0; i < n; i++) begin
            a = v.base + AW'(i);
            exp_q.push_back(regs[a]);
        end
        start    = 1'b1;
        baseAddr = v.base;
        count    = v.cnt;
        step();
        start    = v.noisy;
        baseAddr = AW'($urandom_range(0, 31));
        count    = (AW+1)'($urandom_range(1, 32));
        if (n == 0) begin
            start = 1'b0;
            chk("zero_done", {31'b0, done}, 32'd1);
            chk("zero_busy", {31'b0, busy}, 32'd1);
            chk("zero_valid", {31'b0, outValid}, 32'd0);
            step();
            chk("zero_done_end", {31'b0, done}, 32'd0);
            chk("zero_busy_end", {31'b0, busy}, 32'd0);
            chk("zero_valid_end", {31'b0, outValid}, 32'd0);
            chk("zero_addr_held", {27'b0, regAddr}, {27'b0, v.exp_last_addr});
            return;
        end
        for (int i = 0; i < n; i++) begin
            a = v.base + AW'(i);
            chk("fetch_addr", {27'b0, regAddr}, {27'b0, a});
            chk("fetch_valid", {31'b0, outValid}, 32'd0);
            chk("fetch_busy", {31'b0, busy}, 32'd1);
            chk("fetch_done", {31'b0, done}, 32'd0);
            step();
            if (v.noisy) begin
                baseAddr = AW'($urandom_range(0, 31));
                count    = (AW+1)'($urandom_range(0, 32));
            end
            w = exp_q.pop_front();
            if (i == 0) chk("first_word", outData, v.exp_first);
            chk("present_valid", {31'b0, outValid}, 32'd1);
            chk("present_data", outData, w);
            chk("present_addr", {27'b0, regAddr}, {27'b0, a});
            if (i == v.stall_word) begin
                outReady = 1'b0;
                regs[a]  = ~regs[a];
                for (int k = 0; k < v.stall_len; k++) begin
                    step();
                    chk("stall_valid", {31'b0, outValid}, 32'd1);
                    chk("stall_data", outData, w);
                end
                regs[a]  = ~regs[a];
                outReady = 1'b1;
            end
            step();
        end
        chk("done_pulse", {31'b0, done}, 32'd1);
        chk("done_busy", {31'b0, busy}, 32'd1);
        chk("done_valid", {31'b0, outValid}, 32'd0);
        chk("done_addr", {27'b0, regAddr}, {27'b0, v.exp_last_addr});
        start = 1'b0;
        step();
        chk("idle_done", {31'b0, done}, 32'd0);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_valid", {31'b0, outValid}, 32'd0);
        chk("idle_addr", {27'b0, regAddr}, {27'b0, v.exp_last_addr});
        step();
        chk("idle_stays", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = {16'hC0DE, 8'(i), ~8'(i)};
        regs[2] = 32'hAAAAAAAA;
        regs[3] = 32'h00000005;
        regs[4] = 32'h12345678;

        // base, cnt, stall_word, stall_len, noisy, exp_first, exp_last_addr
        vecs[0] = '{5'd2,  6'd3,  -1, 0, 1'b0, 32'hAAAAAAAA, 5'd4};
        vecs[1] = '{5'd2,  6'd3,   1, 5, 1'b0, 32'hAAAAAAAA, 5'd4};
        vecs[2] = '{5'd30, 6'd4,  -1, 0, 1'b0, 32'hC0DE1EE1, 5'd1};
        vecs[3] = '{5'd0,  6'd0,  -1, 0, 1'b0, 32'h00000000, 5'd1};
        vecs[4] = '{5'd9,  6'd5,   2, 3, 1'b1, 32'hC0DE09F6, 5'd13};
        vecs[5] = '{5'd17, 6'd32, -1, 0, 1'b0, 32'hC0DE11EE, 5'd16};
        vecs[6] = '{5'd31, 6'd1,   0, 2, 1'b1, 32'hC0DE1FE0, 5'd31};

        clear_n  = 1'b0;
        start    = 1'b0;
        baseAddr = '0;
        count    = '0;
        outReady = 1'b1;
        step();
        step();
        chk("rst_valid", {31'b0, outValid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_data", outData, 32'd0);
        chk("rst_addr", {27'b0, regAddr}, 32'd0);
        clear_n = 1'b1;
        step();
        chk("idle_no_start", {31'b0, busy}, 32'd0);

        for (int v = 0; v < 7; v++) run_readback(vecs[v]);

        // Reset while a word is being presented drops it without a done pulse.
        exp_q.delete();
        start    = 1'b1;
        baseAddr = 5'd5;
        count    = 6'd3;
        outReady = 1'b0;
        step();
        start = 1'b0;
        step();
        chk("abort_pre_valid", {31'b0, outValid}, 32'd1);
        chk("abort_pre_data", outData, regs[5]);
        clear_n = 1'b0;
        step();
        chk("abort_valid", {31'b0, outValid}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_data", outData, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_addr", {27'b0, regAddr}, 32'd0);
        clear_n  = 1'b1;
        outReady = 1'b1;
        step();
        chk("abort_no_done", {31'b0, done}, 32'd0);
        chk("abort_idle", {31'b0, busy}, 32'd0);

        run_readback(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
